// File: rtl/alu_if.sv
// Operand, opcode, flag-in and registered-result bundle for the execute-stage ALU.
// The master drives operands and opcode; the slave (the ALU) returns the result and flags.
interface alu_if;
  logic [15:0] In1;
  logic [15:0] In2;
  logic [2:0]  ALUOp;
  logic [2:0]  FLAG_in;
  logic [15:0] ALUOut;
  logic [2:0]  FLAG;

  modport master (output In1, In2, ALUOp, FLAG_in, input ALUOut, FLAG);
  modport slave  (input In1, In2, ALUOp, FLAG_in, output ALUOut, FLAG);
endinterface

// File: rtl/alu.sv
// Registered 16-bit ALU with {Z,V,N} flag update and pass-through of untouched flags.
// Define ALU_PADDSB_EN to build the nibble-saturating PADDSB op; otherwise opcode 111 yields zero.
module alu (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_XOR    = 3'b010;
  localparam logic [2:0] OP_RED    = 3'b011;
  localparam logic [2:0] OP_SLL    = 3'b100;
  localparam logic [2:0] OP_SRA    = 3'b101;
  localparam logic [2:0] OP_ROR    = 3'b110;
  localparam logic [2:0] OP_PADDSB = 3'b111;

  logic [15:0] result_d, result_q;
  logic [2:0]  flag_d, flag_q;

  logic [15:0] addRaw, subRaw, addSat, subSat;
  logic        addOvf, subOvf;
  logic [9:0]  redSum;
  logic [3:0]  shAmt;
  logic [31:0] rotWide;

  // Overflow occurs when the result sign disagrees with the sign both operands imply.
  assign addRaw = bus.In1 + bus.In2;
  assign subRaw = bus.In1 - bus.In2;
  assign addOvf = (bus.In1[15] == bus.In2[15]) && (addRaw[15] != bus.In1[15]);
  assign subOvf = (bus.In1[15] != bus.In2[15]) && (subRaw[15] != bus.In1[15]);
  assign addSat = addOvf ? (bus.In1[15] ? 16'h8000 : 16'h7FFF) : addRaw;
  assign subSat = subOvf ? (bus.In1[15] ? 16'h8000 : 16'h7FFF) : subRaw;

  assign redSum = {{2{bus.In1[15]}}, bus.In1[15:8]} + {{2{bus.In1[7]}}, bus.In1[7:0]}
                + {{2{bus.In2[15]}}, bus.In2[15:8]} + {{2{bus.In2[7]}}, bus.In2[7:0]};

  assign shAmt   = bus.In2[3:0];
  assign rotWide = {bus.In1, bus.In1} >> shAmt;

`ifdef ALU_PADDSB_EN
  function automatic logic [15:0] paddsb(input logic [15:0] a, input logic [15:0] b);
    logic [4:0]  s;
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s = {a[4*i+3], a[4*i +: 4]} + {b[4*i+3], b[4*i +: 4]};
      if (s[4] != s[3]) r[4*i +: 4] = s[4] ? 4'h8 : 4'h7;
      else              r[4*i +: 4] = s[3:0];
    end
    return r;
  endfunction
`endif

  always_comb begin
    result_d = '0;
    flag_d   = bus.FLAG_in;
    case (bus.ALUOp)
      OP_ADD: begin
        result_d = addSat;
        flag_d   = {addSat == 16'h0000, addOvf, addSat[15]};
      end
      OP_SUB: begin
        result_d = subSat;
        flag_d   = {subSat == 16'h0000, subOvf, subSat[15]};
      end
      OP_XOR: begin
        result_d  = bus.In1 ^ bus.In2;
        flag_d[2] = (result_d == 16'h0000);
      end
      OP_RED: result_d = {{6{redSum[9]}}, redSum};
      OP_SLL: result_d = bus.In1 << shAmt;
      OP_SRA: result_d = $signed(bus.In1) >>> shAmt;
      OP_ROR: result_d = rotWide[15:0];
      OP_PADDSB: begin
`ifdef ALU_PADDSB_EN
        result_d = paddsb(bus.In1, bus.In2);
`else
        result_d = '0;
`endif
      end
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
      flag_q   <= '0;
    end else begin
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  assign bus.ALUOut = result_q;
  assign bus.FLAG   = flag_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU: table of ops plus reset/priority sequences.
module tb_alu;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_if bus ();

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  fin;
    logic [15:0] expOut;
    logic [2:0]  expFlag;
  } vec_t;

  vec_t vecs[$];

  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic [2:0] fin);
    bus.ALUOp   = op;
    bus.In1     = a;
    bus.In2     = b;
    bus.FLAG_in = fin;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] expOut,
                             input logic [2:0] expFlag);
    total++;
    if (bus.ALUOut !== expOut || bus.FLAG !== expFlag) begin
      bad++;
      $display("[TB] FAIL %s: got out=%h flag=%b, expected out=%h flag=%b",
               name, bus.ALUOut, bus.FLAG, expOut, expFlag);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vecs.push_back('{"add_basic",   3'b000, 16'h0010, 16'h0004, 3'b000, 16'h0014, 3'b000});
    vecs.push_back('{"add_posovf",  3'b000, 16'h7FFF, 16'h0001, 3'b000, 16'h7FFF, 3'b010});
    vecs.push_back('{"add_negovf",  3'b000, 16'h8000, 16'hFFFF, 3'b000, 16'h8000, 3'b011});
    vecs.push_back('{"add_zero",    3'b000, 16'h0005, 16'hFFFB, 3'b011, 16'h0000, 3'b100});
    vecs.push_back('{"sub_basic",   3'b001, 16'h0014, 16'h0005, 3'b000, 16'h000F, 3'b000});
    vecs.push_back('{"sub_negovf",  3'b001, 16'h8000, 16'h0001, 3'b000, 16'h8000, 3'b011});
    vecs.push_back('{"sub_posovf",  3'b001, 16'h7FFF, 16'hFFFF, 3'b101, 16'h7FFF, 3'b010});
    vecs.push_back('{"xor_zero",    3'b010, 16'hABCD, 16'hABCD, 3'b000, 16'h0000, 3'b100});
    vecs.push_back('{"xor_keepvn",  3'b010, 16'hFF00, 16'h00FF, 3'b011, 16'hFFFF, 3'b011});
    vecs.push_back('{"xor_clrz",    3'b010, 16'h1234, 16'h0000, 3'b111, 16'h1234, 3'b011});
    vecs.push_back('{"red_neg",     3'b011, 16'hFF00, 16'h00FF, 3'b101, 16'hFFFE, 3'b101});
    vecs.push_back('{"red_pos",     3'b011, 16'h1234, 16'h0002, 3'b010, 16'h0048, 3'b010});
    vecs.push_back('{"red_wide",    3'b011, 16'h7F7F, 16'h7F7F, 3'b000, 16'h01FC, 3'b000});
    vecs.push_back('{"sll_4",       3'b100, 16'h0001, 16'hFFF4, 3'b001, 16'h0010, 3'b001});
    vecs.push_back('{"sra_15",      3'b101, 16'h8000, 16'h000F, 3'b110, 16'hFFFF, 3'b110});
    vecs.push_back('{"sra_2",       3'b101, 16'h4000, 16'h0002, 3'b000, 16'h1000, 3'b000});
    vecs.push_back('{"ror_1",       3'b110, 16'h0001, 16'h0001, 3'b000, 16'h8000, 3'b000});
    vecs.push_back('{"ror_0",       3'b110, 16'h1234, 16'h0010, 3'b100, 16'h1234, 3'b100});
    vecs.push_back('{"ror_4",       3'b110, 16'h1234, 16'h0004, 3'b000, 16'h4123, 3'b000});
`ifdef ALU_PADDSB_EN
    vecs.push_back('{"paddsb_pos",  3'b111, 16'h7777, 16'h1111, 3'b101, 16'h7777, 3'b101});
    vecs.push_back('{"paddsb_neg",  3'b111, 16'h8888, 16'hFFFF, 3'b010, 16'h8888, 3'b010});
    vecs.push_back('{"paddsb_mix",  3'b111, 16'h1234, 16'h1111, 3'b000, 16'h2345, 3'b000});
`else
    vecs.push_back('{"paddsb_pos",  3'b111, 16'h7777, 16'h1111, 3'b101, 16'h0000, 3'b101});
    vecs.push_back('{"paddsb_neg",  3'b111, 16'h8888, 16'hFFFF, 3'b010, 16'h0000, 3'b010});
    vecs.push_back('{"paddsb_mix",  3'b111, 16'h1234, 16'h1111, 3'b000, 16'h0000, 3'b000});
`endif

    // Reset held for two edges while a non-trivial op is presented.
    rst_n = 1'b0;
    applyStimulus(3'b000, 16'h7FFF, 16'h0001, 3'b111);
    @(posedge clk); #1;
    checkOutput("reset_edge1", 16'h0000, 3'b000);
    @(posedge clk); #1;
    checkOutput("reset_edge2", 16'h0000, 3'b000);

    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(3'b000, 16'h0010, 16'h0004, 3'b000);
    @(posedge clk); #1;
    checkOutput("reset_release", 16'h0014, 3'b000);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fin);
      @(posedge clk); #1;
      checkOutput(vecs[i].name, vecs[i].expOut, vecs[i].expFlag);
    end

    // Result must hold through the cycle even after inputs change.
    @(negedge clk);
    applyStimulus(3'b001, 16'h8000, 16'h0001, 3'b000);
    @(posedge clk); #1;
    applyStimulus(3'b010, 16'h1111, 16'h2222, 3'b000);
    #3;
    checkOutput("hold_stable", 16'h8000, 3'b011);

    // Reset wins over an op issued in the same cycle.
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(3'b001, 16'h8000, 16'h0001, 3'b111);
    @(posedge clk); #1;
    checkOutput("reset_priority", 16'h0000, 3'b000);

    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(3'b100, 16'h0003, 16'h0002, 3'b010);
    @(posedge clk); #1;
    checkOutput("post_reset_sll", 16'h000C, 3'b010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Registered 16-bit arithmetic/logic unit for the single-cycle processor's execute stage. It computes one of eight operations on two 16-bit operands and registers both the 16-bit result and the 3-bit condition-flag vector. Flags not affected by the current operation are carried through from `FLAG_in`, so the unit also acts as the processor's flag register update path.

## Interface

- Parameters: none. The datapath is fixed at 16 bits.
- Clocking and reset: one clock; reset is synchronous and active-low.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: synchronous, active-low reset.
- `In1` input 16: operand A (rs).
- `In2` input 16: operand B (rt, or shift/rotate amount in `In2[3:0]`).
- `ALUOp` input 3: operation select.
- `FLAG_in` input 3: current flags `{Z,V,N}`; source for any flag an operation does not update.
- `ALUOut` output 16: registered result.
- `FLAG` output 3: registered flags `{Z,V,N}`. `FLAG[2]`=Zero, `FLAG[1]`=Overflow, `FLAG[0]`=Negative.

## Operation

- 000 ADD: signed `In1+In2`, saturating.
  - Positive overflow gives 0x7FFF; negative overflow gives 0x8000.
  - Updates Z, V, N. V=1 on overflow. Z and N are taken from the saturated result.
- 001 SUB: signed `In1-In2`, saturating with the same rules as ADD. Updates Z, V, N.
- 010 XOR: `In1^In2`. Updates Z only. V and N come from `FLAG_in`.
- 011 RED: signed sum of the four bytes `In1[15:8]`, `In1[7:0]`, `In2[15:8]`, `In2[7:0]`.
  - Each byte is sign-extended; the 10-bit sum is sign-extended to 16 bits.
  - No saturation. Flags come from `FLAG_in`.
- 100 SLL: `In1 << In2[3:0]`, zero fill. Flags come from `FLAG_in`.
- 101 SRA: `In1 >>> In2[3:0]`, sign fill. Flags come from `FLAG_in`.
- 110 ROR: `In1` rotated right by `In2[3:0]`. A rotate amount of 0 returns `In1`. Flags come from `FLAG_in`.
- 111 PADDSB: four independent signed 4-bit nibble adds, each saturating to [-8, +7]. No carry between nibbles. Flags come from `FLAG_in`.
- `In2[15:4]` is ignored for the shift and rotate operations.
- All ops are computed combinationally and then captured into the output registers.

## Timing

- Latency is 1 cycle. Inputs sampled at rising edge k appear on `ALUOut`/`FLAG` after edge k and stay stable until edge k+1.
- A new operation can be issued every cycle; there is no handshake and no stall.
- Reset: if `rst_n`=0 at a rising edge, `ALUOut`←0x0000 and `FLAG`←3'b000, regardless of other inputs.
- Reset has priority over any operation issued in the same cycle.
- The first valid result appears one edge after `rst_n` returns high.
- Output values before the first clock edge are undefined until reset has been applied.
- `FLAG_in` is sampled at the same edge as the operands. A flag feedback loop through `FLAG_in` therefore sees the previous result.

## Configuration

- Macro `ALU_PADDSB_EN`.
- Defined: opcode 111 performs PADDSB as specified above.
- Undefined: opcode 111 registers `ALUOut`=0x0000 and `FLAG`=`FLAG_in`, and the nibble-adder logic is not synthesized.
- All other opcodes behave identically in both builds.

## Test plan

- Reset: hold `rst_n`=0 for 2 edges with any inputs → `ALUOut`=0x0000, `FLAG`=000. Release → the next edge produces the normal result.
- ADD 0x0010+0x0004, `FLAG_in`=000 → 0x0014, `FLAG`=000. ADD 0x7FFF+0x0001 → 0x7FFF, `FLAG`=010.
- SUB 0x0014−0x0005 → 0x000F, `FLAG`=000. SUB 0x8000−0x0001 → 0x8000, `FLAG`=011.
- XOR 0xABCD^0xABCD, `FLAG_in`=000 → 0x0000, `FLAG`=100. XOR 0xFF00^0x00FF, `FLAG_in`=011 → 0xFFFF, `FLAG`=011.
- RED 0xFF00/0x00FF → 0xFFFE. RED 0x1234/0x0002 → 0x0048. `FLAG` equals `FLAG_in` in both cases.
- Shifts and PADDSB:
  - SLL 0x0001 by 4 → 0x0010.
  - SRA 0x8000 by 15 → 0xFFFF.
  - ROR 0x0001 by 1 → 0x8000.
  - PADDSB 0x7777+0x1111 → 0x7777; with the macro undefined → 0x0000.
